// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizes for the icache/dcache to unified-memory arbiter.
// Word addresses are split into an icache half and a dcache half by the MSB.
package mem_arbiter_pkg;

   localparam int BEATS   = 4;
   localparam int DATA_W  = 32;
   localparam int BLOCK_W = BEATS * DATA_W;
   localparam int BLK_AW  = 6;
   localparam int WORD_AW = 9;
   localparam int BCNT_W  = $clog2(BEATS);

   localparam logic D_REGION = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      D_ACC,
      I_ACC,
      D_DONE,
      I_DONE
   } state_t;

   typedef enum logic {
      SIDE_D = 1'b0,
      SIDE_I = 1'b1
   } side_t;

endpackage

// File: rtl/mem_arbiter_block_assembler.sv
// Gathers the word-sized beats of an icache block fetch into one wide block.
// bcnt selects the word slot being filled and the address of the next beat.
module block_assembler
   import mem_arbiter_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                capture,
   input  logic [DATA_W-1:0]   word,
   output logic [BCNT_W-1:0]   bcnt,
   output logic [BLOCK_W-1:0]  block,
   output logic                last_beat
);

   logic [BCNT_W-1:0] bcnt_reg;

   assign last_beat = (bcnt_reg == BCNT_W'(BEATS - 1));
   assign bcnt      = bcnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt_reg <= '0;
      end else if (clear) begin
         bcnt_reg <= '0;
      end else if (capture && !last_beat) begin
         bcnt_reg <= bcnt_reg + BCNT_W'(1);
      end
   end

   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
         logic [DATA_W-1:0] word_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               word_reg <= '0;
            end else if (capture && (bcnt_reg == BCNT_W'(gi))) begin
               word_reg <= word;
            end
         end

         assign block[DATA_W*gi +: DATA_W] = word_reg;
      end
   endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the icache (4-beat block reads) and the dcache
// (single-word reads/writes) shared access to one 32-bit unified memory.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic                I_READ,
   input  logic [BLK_AW-1:0]   I_ADDRESS,
   output logic [BLOCK_W-1:0]  I_READDATA,
   output logic                I_BUSYWAIT,
   input  logic                D_READ,
   input  logic                D_WRITE,
   input  logic [BLK_AW-1:0]   D_ADDRESS,
   input  logic [DATA_W-1:0]   D_WRITEDATA,
   output logic [DATA_W-1:0]   D_READDATA,
   output logic                D_BUSYWAIT,
   output logic                MEM_READ,
   output logic                MEM_WRITE,
   output logic [WORD_AW-1:0]  MEM_ADDRESS,
   output logic [DATA_W-1:0]   MEM_WRITEDATA,
   input  logic [DATA_W-1:0]   MEM_READDATA,
   input  logic                MEM_BUSYWAIT
);

   state_t              state_reg, state_next;
   side_t               last_grant_reg;
   logic                seen_busy_reg;
   logic                mem_read_reg, mem_write_reg;
   logic [WORD_AW-1:0]  mem_address_reg;
   logic [DATA_W-1:0]   mem_writedata_reg, d_readdata_reg;

   logic                d_req, access_active, complete;
   logic                grant_d, grant_i, beat_capture, last_beat;
   logic [BCNT_W-1:0]   bcnt;

   assign d_req         = D_READ | D_WRITE;
   assign access_active = mem_read_reg | mem_write_reg;
   // An access ends on the first edge that sees busy low after it was seen high.
   assign complete      = access_active && seen_busy_reg && !MEM_BUSYWAIT;
   assign beat_capture  = (state_reg == I_ACC) && complete;

   block_assembler u_block_assembler (
      .clk       (CLK),
      .rst       (RESET),
      .clear     (grant_i),
      .capture   (beat_capture),
      .word      (MEM_READDATA),
      .bcnt      (bcnt),
      .block     (I_READDATA),
      .last_beat (last_beat)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      grant_d    = 1'b0;
      grant_i    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (d_req && (!I_READ || (last_grant_reg == SIDE_I))) begin
               grant_d    = 1'b1;
               state_next = D_ACC;
            end else if (I_READ) begin
               grant_i    = 1'b1;
               state_next = I_ACC;
            end
         end
         D_ACC:   if (complete) state_next = D_DONE;
         I_ACC:   if (complete && last_beat) state_next = I_DONE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      D_BUSYWAIT = d_req && (state_reg != D_DONE);
      I_BUSYWAIT = I_READ && (state_reg != I_DONE);
   end

   // Strobes are dropped on every completion edge; between icache beats the
   // strobe-low cycle in I_ACC reissues the read for the next word.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         last_grant_reg    <= SIDE_I;
         seen_busy_reg     <= 1'b0;
         mem_read_reg      <= 1'b0;
         mem_write_reg     <= 1'b0;
         mem_address_reg   <= '0;
         mem_writedata_reg <= '0;
         d_readdata_reg    <= '0;
      end else begin
         if (access_active && MEM_BUSYWAIT) begin
            seen_busy_reg <= 1'b1;
         end
         if (grant_d) begin
            mem_write_reg     <= D_WRITE;
            mem_read_reg      <= !D_WRITE;
            mem_address_reg   <= {D_REGION, {(WORD_AW-BLK_AW-1){1'b0}}, D_ADDRESS};
            mem_writedata_reg <= D_WRITEDATA;
            seen_busy_reg     <= 1'b0;
            last_grant_reg    <= SIDE_D;
         end else if (grant_i) begin
            mem_read_reg      <= 1'b1;
            mem_address_reg   <= {~D_REGION, I_ADDRESS, {BCNT_W{1'b0}}};
            seen_busy_reg     <= 1'b0;
            last_grant_reg    <= SIDE_I;
         end else if ((state_reg == D_ACC) && complete) begin
            if (mem_read_reg) begin
               d_readdata_reg <= MEM_READDATA;
            end
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
         end else if ((state_reg == I_ACC) && complete) begin
            mem_read_reg <= 1'b0;
         end else if ((state_reg == I_ACC) && !access_active) begin
            mem_read_reg    <= 1'b1;
            mem_address_reg <= {~D_REGION, I_ADDRESS, bcnt};
            seen_busy_reg   <= 1'b0;
         end
      end
   end

   assign MEM_READ      = mem_read_reg;
   assign MEM_WRITE     = mem_write_reg;
   assign MEM_ADDRESS   = mem_address_reg;
   assign MEM_WRITEDATA = mem_writedata_reg;
   assign D_READDATA    = d_readdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-programmable memory model pops expected
// memory operations from a scoreboard queue as the arbiter issues them.
module tb_mem_arbiter;

   typedef struct packed {
      logic        wr;
      logic [8:0]  addr;
      logic [31:0] data;
   } mem_op_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_read = 1'b0;
   logic [5:0]    i_address = '0;
   logic [127:0]  i_readdata;
   logic          i_busywait;
   logic          d_read = 1'b0;
   logic          d_write = 1'b0;
   logic [5:0]    d_address = '0;
   logic [31:0]   d_writedata = '0;
   logic [31:0]   d_readdata;
   logic          d_busywait;
   logic          mem_read;
   logic          mem_write;
   logic [8:0]    mem_address;
   logic [31:0]   mem_writedata;
   logic [31:0]   mem_readdata = '0;
   logic          mem_busywait = 1'b0;

   int            checks = 0;
   int            errors = 0;
   mem_op_t       exp_q[$];
   int            mem_lat = 2;
   int            mem_cnt = 0;
   logic [31:0]   mem_arr [512];
   logic [511:0]  mem_written = '0;

   mem_arbiter dut (
      .CLK           (clk),
      .RESET         (rst),
      .I_READ        (i_read),
      .I_ADDRESS     (i_address),
      .I_READDATA    (i_readdata),
      .I_BUSYWAIT    (i_busywait),
      .D_READ        (d_read),
      .D_WRITE       (d_write),
      .D_ADDRESS     (d_address),
      .D_WRITEDATA   (d_writedata),
      .D_READDATA    (d_readdata),
      .D_BUSYWAIT    (d_busywait),
      .MEM_READ      (mem_read),
      .MEM_WRITE     (mem_write),
      .MEM_ADDRESS   (mem_address),
      .MEM_WRITEDATA (mem_writedata),
      .MEM_READDATA  (mem_readdata),
      .MEM_BUSYWAIT  (mem_busywait)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Power-up content of words never written by the bench.
   function automatic logic [31:0] init_word(input logic [8:0] a);
      if (a[7:2] == 6'h05)
         return 32'h11111111 * ({30'd0, a[1:0]} + 32'd1);
      else
         return {16'hA5A5, 7'h00, a};
   endfunction

   function automatic logic [127:0] exp_block(input logic [5:0] a);
      return {init_word({1'b0, a, 2'd3}), init_word({1'b0, a, 2'd2}),
              init_word({1'b0, a, 2'd1}), init_word({1'b0, a, 2'd0})};
   endfunction

   task automatic sb_pop();
      mem_op_t e;
      check("sb_pending", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("mem_strobe", 128'({mem_write, mem_read}), e.wr ? 128'd2 : 128'd1);
         check("mem_addr", 128'(mem_address), 128'(e.addr));
         if (e.wr)
            check("mem_wdata", 128'(mem_writedata), 128'(e.data));
         $display("mem %s addr %03h wdata %08h", mem_write ? "wr" : "rd", mem_address, mem_writedata);
      end
   endtask

   // Memory model: busy for mem_lat cycles from the first negedge that sees a strobe.
   always @(negedge clk) begin
      if (rst) begin
         mem_busywait <= 1'b0;
         mem_cnt      <= 0;
      end else if (mem_busywait) begin
         if (mem_cnt <= 1) begin
            mem_busywait <= 1'b0;
            if (mem_write) begin
               mem_arr[mem_address]     <= mem_writedata;
               mem_written[mem_address] <= 1'b1;
            end else begin
               mem_readdata <= mem_written[mem_address] ? mem_arr[mem_address] : init_word(mem_address);
            end
         end else begin
            mem_cnt <= mem_cnt - 1;
         end
      end else if (mem_read || mem_write) begin
         mem_busywait <= 1'b1;
         mem_cnt      <= mem_lat;
         sb_pop();
      end
   end

   task automatic push_op(input logic wr, input logic [8:0] a, input logic [31:0] data);
      mem_op_t e;
      e.wr   = wr;
      e.addr = a;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic push_i(input logic [5:0] a);
      for (int k = 0; k < 4; k++)
         push_op(1'b0, {1'b0, a, 2'(k)}, 32'h0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic wait_i(input logic [127:0] expv, input string tag);
      bit ok = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (!i_busywait) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_done"}, 128'(ok), 128'd1);
      check({tag, "_blk"}, i_readdata, expv);
      i_read = 1'b0;
   endtask

   task automatic icache_op(input logic [5:0] a, input logic [127:0] expv, input string tag);
      @(negedge clk);
      push_i(a);
      i_address = a;
      i_read    = 1'b1;
      @(negedge clk);
      check({tag, "_grant"}, 128'(mem_read), 128'd1);
      wait_i(expv, tag);
   endtask

   task automatic dcache_op(input logic wr, input logic rd, input logic [5:0] a,
                            input logic [31:0] data, input logic [31:0] exp_rd, input string tag);
      bit ok = 1'b0;
      @(negedge clk);
      push_op(wr, {1'b1, 2'b00, a}, wr ? data : 32'h0);
      d_address   = a;
      d_writedata = data;
      d_write     = wr;
      d_read      = rd;
      @(negedge clk);
      check({tag, "_grant"}, 128'({mem_write, mem_read}), wr ? 128'd2 : 128'd1);
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (!d_busywait) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_done"}, 128'(ok), 128'd1);
      if (!wr)
         check({tag, "_rdata"}, 128'(d_readdata), 128'(exp_rd));
      d_read  = 1'b0;
      d_write = 1'b0;
   endtask

   initial begin
      int  d_phase;
      bit  i_fin;
      bit  found;

      // Reset raised at t=1 with an icache request already pending.
      #1 rst = 1'b1;
      i_read    = 1'b1;
      i_address = 6'h00;
      repeat (3) @(negedge clk);
      check("rst_mem_read", 128'(mem_read), 128'd0);
      check("rst_mem_write", 128'(mem_write), 128'd0);
      check("rst_mem_addr", 128'(mem_address), 128'd0);
      check("rst_mem_wdata", 128'(mem_writedata), 128'd0);
      check("rst_i_rdata", i_readdata, 128'd0);
      check("rst_d_rdata", 128'(d_readdata), 128'd0);
      check("rst_i_busy", 128'(i_busywait), 128'd1);
      check("rst_d_busy", 128'(d_busywait), 128'd0);
      push_i(6'h00);
      #2 rst = 1'b0;
      wait_i(exp_block(6'h00), "rst_first");

      // Block fetch with a slow memory.
      mem_lat = 5;
      icache_op(6'h05, 128'h44444444_33333333_22222222_11111111, "ifetch");

      // Dcache write then read-back.
      mem_lat = 2;
      dcache_op(1'b1, 1'b0, 6'h02, 32'hDEADBEEF, 32'h0, "dwr");
      dcache_op(1'b0, 1'b1, 6'h02, 32'h0, 32'hDEADBEEF, "drd");

      // Simultaneous requests after reset: dcache first, then a second tie goes to icache.
      apply_reset();
      @(negedge clk);
      mem_lat = 3;
      push_op(1'b0, 9'h102, 32'h0);
      push_i(6'h05);
      push_op(1'b1, 9'h105, 32'hCAFEF00D);
      d_address = 6'h02;
      d_read    = 1'b1;
      i_address = 6'h05;
      i_read    = 1'b1;
      d_phase   = 0;
      i_fin     = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (d_phase == 1) begin
            d_address   = 6'h05;
            d_writedata = 32'hCAFEF00D;
            d_write     = 1'b1;
            d_phase     = 2;
         end else if ((d_phase == 0 || d_phase == 2) && !d_busywait) begin
            if (d_phase == 0) begin
               check("tie_drd", 128'(d_readdata), 128'hDEADBEEF);
               check("tie_i_wait", 128'(i_busywait), 128'd1);
               d_read  = 1'b0;
               d_phase = 1;
            end else begin
               d_write = 1'b0;
               d_phase = 3;
            end
         end
         if (i_read && !i_busywait) begin
            check("tie_iblk", i_readdata, 128'h44444444_33333333_22222222_11111111);
            check("tie_d_wait", 128'(d_busywait), 128'd1);
            i_read = 1'b0;
            i_fin  = 1'b1;
         end
         if (d_phase == 3 && i_fin)
            break;
      end
      check("tie_done", 128'(d_phase == 3 && i_fin), 128'd1);

      // Reset during beat 2 of a block fetch, then restart from beat 0.
      @(negedge clk);
      push_i(6'h05);
      i_address = 6'h05;
      i_read    = 1'b1;
      found     = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (mem_read && mem_address == 9'h016) begin
            found = 1'b1;
            break;
         end
      end
      check("rstmid_beat2", 128'(found), 128'd1);
      #2 rst = 1'b1;
      #1;
      check("rstmid_read", 128'(mem_read), 128'd0);
      check("rstmid_addr", 128'(mem_address), 128'd0);
      check("rstmid_iblk", i_readdata, 128'd0);
      check("rstmid_ibusy", 128'(i_busywait), 128'd1);
      exp_q.delete();
      push_i(6'h05);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      wait_i(128'h44444444_33333333_22222222_11111111, "rstmid_restart");

      // Read and write together: only the write reaches memory.
      dcache_op(1'b1, 1'b1, 6'h07, 32'h12345678, 32'h0, "drw");
      dcache_op(1'b0, 1'b1, 6'h07, 32'h0, 32'h12345678, "drw_rd");

      repeat (4) @(negedge clk);
      check("sb_empty", 128'(exp_q.size()), 128'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-memory arbiter sitting between the instruction cache and data cache and a single 32-bit-wide unified main memory, replacing the two private memories. It accepts 128-bit block fetches from the icache, issuing them as four sequential word reads, and single-word read/write requests from the dcache. It arbitrates round-robin between the two when both are pending, and drives each cache's busywait with the same handshake the caches already use toward memory.

## Interface
- BEATS, 4: words per icache block
- D_REGION, 1'b1: MSB of the memory word address for dcache traffic (icache uses ~D_REGION)
- CLK in 1: clock, all state on posedge
- RESET in 1: asynchronous, active-high reset
- I_READ in 1: icache block read request, held until completion
- I_ADDRESS in 6: icache block address
- I_READDATA out 128: assembled block; word k at bits [32k+31:32k]
- I_BUSYWAIT out 1: icache stall
- D_READ in 1: dcache word read request
- D_WRITE in 1: dcache word write request
- D_ADDRESS in 6: dcache block (word) address
- D_WRITEDATA in 32: dcache write data
- D_READDATA out 32: dcache read data
- D_BUSYWAIT out 1: dcache stall
- MEM_READ out 1: registered memory read strobe
- MEM_WRITE out 1: registered memory write strobe
- MEM_ADDRESS out 9: word address
- MEM_WRITEDATA out 32: write data
- MEM_READDATA in 32: read data
- MEM_BUSYWAIT in 1: memory busy

## Operation
- States: IDLE, D_ACC, I_ACC, D_DONE, I_DONE. Beat counter bcnt (2 bits), last_grant flag, seen_busy flag.
- IDLE: D request = D_READ|D_WRITE. Only one pending -> grant it. Both pending -> grant the side not equal to last_grant. Grant registers MEM_* for the first access, clears seen_busy, and updates last_grant.
- D_ACC: MEM_ADDRESS={D_REGION,2'b00,D_ADDRESS}. D_WRITE has priority over D_READ if both are asserted; MEM_WRITEDATA is latched at grant.
- I_ACC: MEM_ADDRESS={~D_REGION,I_ADDRESS,bcnt}, bcnt starts at 0.
- Access completion: a posedge with seen_busy=1 and MEM_BUSYWAIT=0. seen_busy is set on any posedge where MEM_BUSYWAIT=1 during an access.
- On completion in D_ACC: capture MEM_READDATA into D_READDATA on reads; drop strobes; go to D_DONE.
- On completion in I_ACC: write MEM_READDATA into word bcnt of the block buffer.
  - bcnt<3: drop strobes for exactly one cycle, then reissue with bcnt+1 and clear seen_busy.
  - bcnt=3: go to I_DONE.
- D_DONE / I_DONE: one cycle, then IDLE. The cache drops its request on the same edge.
- Busywait outputs:
  - X_BUSYWAIT = X request asserted AND state is not X_DONE.
  - In X_DONE, X_BUSYWAIT=0 and X_READDATA is valid.
- X_READDATA holds its value until overwritten by the next completed transfer for X.
- A request deasserted mid-access (protocol violation) does not abort the access; the result is discarded at DONE.
- Reset values: state IDLE, all MEM_* 0, I_READDATA 0, D_READDATA 0, bcnt 0, seen_busy 0, last_grant=I (dcache wins the first tie). D_BUSYWAIT/I_BUSYWAIT follow their combinational rule with state IDLE.
- RESET mid-access returns to these values immediately, with no completion signalled.

## Timing
- Memory contract: MEM_BUSYWAIT rises no later than the first posedge after a strobe is asserted.
- Grant latency: the strobe is asserted on the posedge after the request is seen in IDLE.
- Dcache transaction, memory busy M cycles: 1 (grant) + M + 1 (DONE) cycles of busywait-low-to-low span.
- Icache transaction: 1 + 4·M + 3 (gap cycles) + 1 cycles.
- Non-preemptive: a pending request waits for the full in-flight transaction, plus the IDLE cycle.
- Strobes never stay asserted across a completion edge.

## Structure
- Package mem_arbiter_pkg: state enum, BEATS, address widths (block 6, word 9), side encoding for last_grant.
- Sub-module block_assembler: bcnt counter, 128-bit word-indexed buffer, last_beat flag.
- The FSM and arbitration stay in mem_arbiter.

## Test plan
- Reset asserted at t=1 with I_READ=1 -> all MEM_* 0, I_BUSYWAIT=1, no strobe until RESET falls. The first strobe is MEM_READ with MEM_ADDRESS=9'h000.
- Icache read, I_ADDRESS=6'h05, memory words 0x11111111..0x44444444 at 0x014–0x017, M=5 -> four MEM_READ bursts at 0x014,0x015,0x016,0x017. I_READDATA=0x44444444_33333333_22222222_11111111 in I_DONE; I_BUSYWAIT low exactly that cycle.
- Dcache write D_ADDRESS=6'h02, data 0xDEADBEEF, then read 6'h02 -> MEM_WRITE at 0x102 with 0xDEADBEEF; the read returns D_READDATA=0xDEADBEEF.
- D_READ and I_READ rising on the same edge after reset -> dcache granted first. The icache access starts the cycle after D_DONE+IDLE. A second tie after that grants the icache.
- RESET pulsed during beat 2 of an icache fetch -> strobes 0 and I_READDATA=0 immediately. The fetch restarts from beat 0 after release.
- D_READ and D_WRITE asserted together -> only MEM_WRITE is issued.
